gsm_cmd_receiver: RTL and testbench

- Downlink counterpart of the meter's SMS alert path: parses ASCII command frames arriving byte-by-byte from the GSM modem.
- Turns each valid frame into control actions for the meter: energy counter reset, reading query, load disconnect/connect, and alert threshold update.
- Sits between the GSM modem byte interface and the DSP/MCU blocks.

---
 rtl/gsm_cmd_pkg.sv | 34 +++
 rtl/gsm_arg_accum.sv | 56 +++++
 rtl/gsm_cmd_receiver.sv | 180 ++++++++++++++++++
 tb/tb_gsm_cmd_receiver.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gsm_cmd_pkg.sv
// Shared definitions for the GSM downlink command receiver.
//   - state_t : receiver FSM states
//   - ASCII framing and command characters
//   - small byte classification helpers
package gsm_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ARG,
    ST_EXEC,
    ST_DISCARD
  } state_t;

  localparam logic [7:0] START   = 8'h23;  // '#'
  localparam logic [7:0] END     = 8'h2A;  // '*'
  localparam logic [7:0] CMD_R   = 8'h52;  // meter reset
  localparam logic [7:0] CMD_Q   = 8'h51;  // query reading
  localparam logic [7:0] CMD_D   = 8'h44;  // disconnect load
  localparam logic [7:0] CMD_C   = 8'h43;  // connect load
  localparam logic [7:0] CMD_T   = 8'h54;  // set threshold
  localparam logic [7:0] DIGIT_0 = 8'h30;  // '0'

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= DIGIT_0) && (b <= DIGIT_0 + 8'd9);
  endfunction

  // Uppercase only; lowercase letters fall through as invalid.
  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_R) || (b == CMD_Q) || (b == CMD_D) ||
           (b == CMD_C) || (b == CMD_T);
  endfunction

endpackage

// File: rtl/gsm_arg_accum.sv
// Decimal argument accumulator for the command receiver.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   clear             : zero the argument and digit count (next edge)
//   digit_vld, digit  : append one decimal digit (ignored when ovf is high)
//   arg_value         : accumulated argument
//   digit_cnt         : digits accepted so far
//   ovf               : appending 'digit' now would exceed MAX_DIGITS or 65535
module gsm_arg_accum #(
  parameter  int MAX_DIGITS = 5,
  localparam int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             digit_vld,
  input  logic [3:0]       digit,
  output logic [15:0]      arg_value,
  output logic [CNT_W-1:0] digit_cnt,
  output logic             ovf
);

  logic [15:0]      arg_q, arg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [16:0]      next_val;

  always_comb begin
    // The digit-count guard keeps arg below 10^(MAX_DIGITS-1) here, so a
    // 17-bit product cannot wrap before bit 16 flags the overflow.
    next_val = 17'(arg_q) * 17'd10 + 17'(digit);
    ovf      = (cnt_q == CNT_W'(MAX_DIGITS)) || next_val[16];
    arg_d    = arg_q;
    cnt_d    = cnt_q;
    if (clear) begin
      arg_d = '0;
      cnt_d = '0;
    end else if (digit_vld && !ovf) begin
      arg_d = next_val[15:0];
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arg_q <= '0;
      cnt_q <= '0;
    end else begin
      arg_q <= arg_d;
      cnt_q <= cnt_d;
    end
  end

  assign arg_value = arg_q;
  assign digit_cnt = cnt_q;

endmodule

// File: rtl/gsm_cmd_receiver.sv
// GSM downlink command receiver: parses "#<cmd>[digits]*" frames from the
// modem byte stream and drives meter control actions.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   rx_byte, rx_valid     : modem byte stream
//   rx_ready              : byte accepted on an edge with rx_valid && rx_ready
//   meter_reset, query_req: one-cycle action pulses
//   load_enable           : load connected level
//   threshold_value/_wr   : alert threshold and its update pulse
//   cmd_error             : one-cycle pulse for a rejected/aborted frame
//   cmd_count             : executed command counter (wraps)
module gsm_cmd_receiver
  import gsm_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES    = 1000,
  parameter int THRESHOLD_DEFAULT = 100,
  parameter int MAX_DIGITS        = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        meter_reset,
  output logic        query_req,
  output logic        load_enable,
  output logic [15:0] threshold_value,
  output logic        threshold_wr,
  output logic        cmd_error,
  output logic [7:0]  cmd_count
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  state_t           state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             load_enable_q, load_enable_d;
  logic [15:0]      threshold_q, threshold_d;
  logic [7:0]       cmd_count_q, cmd_count_d;
  logic             meter_reset_q, meter_reset_d;
  logic             query_req_q, query_req_d;
  logic             threshold_wr_q, threshold_wr_d;
  logic             cmd_error_q, cmd_error_d;

  logic             xfer, legal_cnt;
  logic             acc_clear, acc_digit_vld, acc_ovf;
  logic [15:0]      acc_value;
  logic [CNT_W-1:0] acc_cnt;

  gsm_arg_accum #(.MAX_DIGITS(MAX_DIGITS)) u_accum (
    .clk       (clk),
    .reset     (reset),
    .clear     (acc_clear),
    .digit_vld (acc_digit_vld),
    .digit     (rx_byte[3:0]),
    .arg_value (acc_value),
    .digit_cnt (acc_cnt),
    .ovf       (acc_ovf)
  );

  assign rx_ready  = (state_q != ST_EXEC);
  assign xfer      = rx_valid && rx_ready;
  assign legal_cnt = (cmd_q == CMD_T) ? (acc_cnt != '0) : (acc_cnt == '0);

  always_comb begin
    state_d        = state_q;
    cmd_d          = cmd_q;
    tmo_d          = '0;
    load_enable_d  = load_enable_q;
    threshold_d    = threshold_q;
    cmd_count_d    = cmd_count_q;
    meter_reset_d  = 1'b0;
    query_req_d    = 1'b0;
    threshold_wr_d = 1'b0;
    cmd_error_d    = 1'b0;
    acc_clear      = 1'b0;
    acc_digit_vld  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (xfer && rx_byte == START) begin
          state_d   = ST_CMD;
          acc_clear = 1'b1;
        end
      end
      ST_EXEC: begin
        state_d     = ST_IDLE;
        cmd_count_d = cmd_count_q + 8'd1;
      end
      default: begin  // CMD, ARG, DISCARD: inside a frame
        if (xfer && rx_byte == START) begin
          // Resynchronise on a fresh start marker; the old frame is lost.
          state_d     = ST_CMD;
          acc_clear   = 1'b1;
          cmd_error_d = 1'b1;
        end else if (xfer) begin
          if (state_q == ST_CMD) begin
            if (is_cmd(rx_byte)) begin
              cmd_d   = rx_byte;
              state_d = ST_ARG;
            end else begin
              state_d = ST_DISCARD;
            end
          end else if (state_q == ST_ARG) begin
            if (is_digit(rx_byte)) begin
              if (acc_ovf) state_d = ST_DISCARD;
              else         acc_digit_vld = 1'b1;
            end else if (rx_byte == END) begin
              if (legal_cnt) begin
                // Pulses are registered so they appear exactly in EXEC.
                state_d = ST_EXEC;
                case (cmd_q)
                  CMD_R: meter_reset_d = 1'b1;
                  CMD_Q: query_req_d   = 1'b1;
                  CMD_D: load_enable_d = 1'b0;
                  CMD_C: load_enable_d = 1'b1;
                  CMD_T: begin
                    threshold_d    = acc_value;
                    threshold_wr_d = 1'b1;
                  end
                  default: ;
                endcase
              end else begin
                state_d     = ST_IDLE;
                cmd_error_d = 1'b1;
              end
            end else begin
              state_d = ST_DISCARD;
            end
          end else if (rx_byte == END) begin
            state_d     = ST_IDLE;
            cmd_error_d = 1'b1;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = ST_IDLE;
          cmd_error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cmd_q          <= '0;
      tmo_q          <= '0;
      load_enable_q  <= 1'b1;
      threshold_q    <= 16'(THRESHOLD_DEFAULT);
      cmd_count_q    <= '0;
      meter_reset_q  <= 1'b0;
      query_req_q    <= 1'b0;
      threshold_wr_q <= 1'b0;
      cmd_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      tmo_q          <= tmo_d;
      load_enable_q  <= load_enable_d;
      threshold_q    <= threshold_d;
      cmd_count_q    <= cmd_count_d;
      meter_reset_q  <= meter_reset_d;
      query_req_q    <= query_req_d;
      threshold_wr_q <= threshold_wr_d;
      cmd_error_q    <= cmd_error_d;
    end
  end

  assign meter_reset     = meter_reset_q;
  assign query_req       = query_req_q;
  assign load_enable     = load_enable_q;
  assign threshold_value = threshold_q;
  assign threshold_wr    = threshold_wr_q;
  assign cmd_error       = cmd_error_q;
  assign cmd_count       = cmd_count_q;

endmodule

// File: tb/tb_gsm_cmd_receiver.sv
// Bench for gsm_cmd_receiver: directed frame table, hand-written timing
// sequences and randomized frames, all checked cycle by cycle against a
// frame-level reference model.
module tb_gsm_cmd_receiver;

  localparam int TMO  = 1000;
  localparam int THR0 = 100;
  localparam int MAXD = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, meter_reset, query_req, load_enable;
  logic [15:0] threshold_value;
  logic        threshold_wr, cmd_error;
  logic [7:0]  cmd_count;

  gsm_cmd_receiver #(
    .TIMEOUT_CYCLES(TMO), .THRESHOLD_DEFAULT(THR0), .MAX_DIGITS(MAXD)
  ) dut (
    .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .meter_reset(meter_reset), .query_req(query_req),
    .load_enable(load_enable), .threshold_value(threshold_value),
    .threshold_wr(threshold_wr), .cmd_error(cmd_error), .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (frame level) ----------------
  logic        m_in_frame = 1'b0;
  logic [7:0]  m_buf[$];
  int          m_idle = 0;
  logic        m_exec = 1'b0;
  logic        m_mr = 1'b0, m_q = 1'b0, m_wr = 1'b0, m_err = 1'b0, m_ld = 1'b1;
  logic [15:0] m_thr = 16'(THR0);
  logic [7:0]  m_cnt = 8'd0;
  logic        m_xfer;
  logic [15:0] m_val;

  // Whole-frame validation: f[0] is the command, the rest must be digits.
  function automatic logic frame_ok(input logic [7:0] f[$], output logic [15:0] val);
    int     n = f.size() - 1;
    longint v = 0;
    logic [7:0] c = f[0];
    val = '0;
    if (!(c inside {8'h52, 8'h51, 8'h44, 8'h43, 8'h54})) return 1'b0;
    if (n > MAXD) return 1'b0;
    for (int i = 1; i <= n; i++) begin
      if (f[i] < 8'h30 || f[i] > 8'h39) return 1'b0;
      v = v * 10 + longint'(f[i]) - 48;
    end
    if (c == 8'h54) begin
      if (n == 0 || v > 65535) return 1'b0;
    end else if (n != 0) begin
      return 1'b0;
    end
    val = v[15:0];
    return 1'b1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_in_frame = 1'b0; m_buf.delete(); m_idle = 0; m_exec = 1'b0;
      m_mr = 1'b0; m_q = 1'b0; m_wr = 1'b0; m_err = 1'b0;
      m_ld = 1'b1; m_thr = 16'(THR0); m_cnt = 8'd0;
    end else begin
      m_xfer = rx_valid && !m_exec;
      m_mr = 1'b0; m_q = 1'b0; m_wr = 1'b0; m_err = 1'b0;
      if (m_exec) begin
        m_exec = 1'b0;
        m_cnt  = m_cnt + 8'd1;
      end else if (m_in_frame) begin
        if (m_xfer) begin
          m_idle = 0;
          if (rx_byte == 8'h23) begin
            m_buf.delete();
            m_err = 1'b1;
          end else if (rx_byte == 8'h2A && m_buf.size() > 0) begin
            m_in_frame = 1'b0;
            if (frame_ok(m_buf, m_val)) begin
              m_exec = 1'b1;
              case (m_buf[0])
                8'h52: m_mr = 1'b1;
                8'h51: m_q  = 1'b1;
                8'h44: m_ld = 1'b0;
                8'h43: m_ld = 1'b1;
                default: begin m_thr = m_val; m_wr = 1'b1; end
              endcase
            end else begin
              m_err = 1'b1;
            end
          end else begin
            m_buf.push_back(rx_byte);
          end
        end else begin
          m_idle++;
          if (m_idle >= TMO) begin
            m_in_frame = 1'b0;
            m_err = 1'b1;
          end
        end
      end else if (m_xfer && rx_byte == 8'h23) begin
        m_in_frame = 1'b1;
        m_buf.delete();
        m_idle = 0;
      end
    end
  end

  // ---------------- checking infrastructure ----------------
  int vectors = 0, miscompares = 0;
  int n_mr = 0, n_q = 0, n_wr = 0, n_err = 0;
  logic [29:0] dut_vec, mdl_vec;
  assign dut_vec = {rx_ready, meter_reset, query_req, load_enable, threshold_value,
                    threshold_wr, cmd_error, cmd_count};
  assign mdl_vec = {!m_exec, m_mr, m_q, m_ld, m_thr, m_wr, m_err, m_cnt};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("cycle", 32'(dut_vec), 32'(mdl_vec));
    n_mr  += int'(meter_reset);
    n_q   += int'(query_req);
    n_wr  += int'(threshold_wr);
    n_err += int'(cmd_error);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      rx_byte = 8'($urandom);
      tick();
    end
  endtask

  task automatic send(input logic [7:0] b);
    int   w = 0;
    logic rdy;
    rx_valid = 1'b1;
    rx_byte  = b;
    do begin
      rdy = rx_ready;
      tick();
      w++;
    end while (!rdy && w < 4);
    if (!rdy) begin
      vectors++;
      miscompares++;
      $display("FAIL send_wait byte %h: rx_ready stayed 0, required 1", b);
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic clr_counts();
    n_mr = 0; n_q = 0; n_wr = 0; n_err = 0;
  endtask

  task automatic rand_frame();
    logic [7:0] cmds [8] = '{8'h52, 8'h51, 8'h44, 8'h43, 8'h54, 8'h54, 8'h58, 8'h72};
    logic [7:0] q[$];
    int nd = $urandom_range(0, 6);
    int stall_at = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, nd + 2)) : -1;
    if ($urandom_range(0, 9) == 0) q.push_back(8'($urandom_range(32, 126)));
    q.push_back(8'h23);
    q.push_back(cmds[$urandom_range(0, 7)]);
    for (int i = 0; i < nd; i++) begin
      case ($urandom_range(0, 24))
        0:       q.push_back(8'h23);
        1:       q.push_back(8'h61);
        2, 3, 4: q.push_back(8'h39);
        default: q.push_back(8'(8'h30 + $urandom_range(0, 9)));
      endcase
    end
    q.push_back(8'h2A);
    foreach (q[i]) begin
      if (i == stall_at)                idle(TMO - 1 + int'($urandom_range(0, 1)));
      else if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(1, 3)));
      send(q[i]);
    end
  endtask

  typedef struct {
    string       frame;
    int          mr, q, wr, err;
    logic        ld;
    logic [15:0] thr;
    int          dcnt;
  } vec_t;

  localparam int NROWS = 13;
  vec_t tbl [NROWS];
  logic [7:0] base;

  initial begin
    tbl[0]  = '{"#D*",       0, 0, 0, 0, 1'b0, 16'd100,   1};
    tbl[1]  = '{"#C*",       0, 0, 0, 0, 1'b1, 16'd100,   1};
    tbl[2]  = '{"#T250*",    0, 0, 1, 0, 1'b1, 16'd250,   1};
    tbl[3]  = '{"#T70000*",  0, 0, 0, 1, 1'b1, 16'd250,   0};
    tbl[4]  = '{"#X*",       0, 0, 0, 1, 1'b1, 16'd250,   0};
    tbl[5]  = '{"#T*",       0, 0, 0, 1, 1'b1, 16'd250,   0};
    tbl[6]  = '{"#Q5*",      0, 0, 0, 1, 1'b1, 16'd250,   0};
    tbl[7]  = '{"#q*",       0, 0, 0, 1, 1'b1, 16'd250,   0};
    tbl[8]  = '{"#T65535*",  0, 0, 1, 0, 1'b1, 16'd65535, 1};
    tbl[9]  = '{"#T123456*", 0, 0, 0, 1, 1'b1, 16'd65535, 0};
    tbl[10] = '{"#T4#R*",    1, 0, 0, 1, 1'b1, 16'd65535, 1};
    tbl[11] = '{"xx#Q*",     0, 1, 0, 0, 1'b1, 16'd65535, 1};
    tbl[12] = '{"#T00007*",  0, 0, 1, 0, 1'b1, 16'd7,     1};

    reset = 1'b1;
    repeat (3) tick();
    chk("rst_ready", 32'(rx_ready), 32'd1);
    chk("rst_load", 32'(load_enable), 32'd1);
    chk("rst_thr", 32'(threshold_value), 32'(THR0));
    chk("rst_count", 32'(cmd_count), 32'd0);
    chk("rst_pulses", 32'({meter_reset, query_req, threshold_wr, cmd_error}), 32'd0);
    reset = 1'b0;
    idle(2);

    // "#R*": pulse and stalled ready in the cycle right after the '*' edge
    send_str("#R");
    send(8'h2A);
    chk("r_pulse_ready_cnt", 32'({meter_reset, rx_ready, cmd_count}), 32'({1'b1, 1'b0, 8'd0}));
    tick();
    chk("r_after", 32'({meter_reset, rx_ready, cmd_count}), 32'({1'b0, 1'b1, 8'd1}));
    idle(2);

    for (int r = 0; r < NROWS; r++) begin
      base = cmd_count;
      clr_counts();
      send_str(tbl[r].frame);
      idle(3);
      chk($sformatf("row%0d_pulses", r),
          {8'(n_mr), 8'(n_q), 8'(n_wr), 8'(n_err)},
          {8'(tbl[r].mr), 8'(tbl[r].q), 8'(tbl[r].wr), 8'(tbl[r].err)});
      chk($sformatf("row%0d_state", r),
          32'({load_enable, threshold_value, 8'(cmd_count - base)}),
          32'({tbl[r].ld, tbl[r].thr, 8'(tbl[r].dcnt)}));
    end

    // Inter-byte timeout: abort exactly TMO idle cycles after the last byte.
    clr_counts();
    send_str("#T12");
    idle(TMO - 1);
    chk("tmo_not_yet", 32'(n_err), 32'd0);
    idle(1);
    chk("tmo_err", 32'(n_err), 32'd1);
    send_str("#Q*");
    idle(3);
    chk("tmo_then_q", 32'({8'(n_q), 8'(n_wr), threshold_value}), 32'({8'd1, 8'd0, 16'd7}));

    // Reset mid-frame restores defaults and produces no action.
    send_str("#D*");
    idle(2);
    clr_counts();
    send_str("#T9");
    reset = 1'b1;
    #1;
    chk("midrst_vals", 32'({rx_ready, load_enable, threshold_value, cmd_count}),
        32'({1'b1, 1'b1, 16'(THR0), 8'd0}));
    tick();
    reset = 1'b0;
    send_str("5*");
    idle(3);
    chk("midrst_noact", 32'({8'(n_wr), 8'(n_err), threshold_value}), 32'({8'd0, 8'd0, 16'(THR0)}));

    // Randomized frames against the model (cycle-by-cycle checks in tick).
    for (int f = 0; f < 300; f++) begin
      rand_frame();
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(0, 2)));
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
